dbg_scan_ctrl: RTL and testbench
================================

Name: dbg_scan_ctrl

Overview:
Sequencer for the debug inspection path of the pipelined MIPS board build.
- Drives the shared debug read port of the register file and data memory.
- Reads one word per address, either at a switch-selected address (manual) or walking all addresses on a timed dwell (auto).
- Latches each returned word with its address for the seven-segment and LED display mux.
- Replaces the free-running address counter with a handshaken, timeout-protected controller.

Parameters:
ADDR_W, 7, width of inspection address.
LAST_ADDR, 127, highest address scanned in auto mode; wraps to 0 after it.
DWELL, 25000000, clk cycles each address is held in auto mode (must be >= 2).
TIMEOUT, 15, max cycles from grant to rd_valid before the read is declared failed.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
mode_auto  in  1  1 = auto scan, 0 = manual
sel_addr  in  ADDR_W  manual-mode address (from switches)
src_sel  in  1  0 = register file, 1 = data memory
step  in  1  synchronised button level; rising edge advances scan
rd_req  out  1  read request to shared debug port
rd_addr  out  ADDR_W  read address, stable while rd_req high
rd_src  out  1  read source, stable while rd_req high
rd_gnt  in  1  port grant; transfer accepted in cycle rd_req & rd_gnt
rd_valid  in  1  read data valid, one-cycle pulse
rd_data  in  32  read data
show_addr  out  ADDR_W  address of displayed word
show_data  out  32  displayed word
show_valid  out  1  show_data holds a completed read
rd_err  out  1  last read timed out
busy  out  1  transaction in flight (REQ or WAIT)

Behaviour:
Reset (rst_n low, asynchronous):
- rd_req, rd_addr, rd_src, show_addr, show_data, show_valid, rd_err, busy all 0.
- Scan address 0, dwell counter 0, state IDLE.
- The step edge detector's previous value is cleared to 0.
- Reset asserted mid-transaction aborts it immediately. A late rd_valid after reset release is ignored because the state is IDLE.

States:
- IDLE: waits for a trigger.
- REQ: rd_req = 1, holding rd_addr/rd_src until rd_gnt.
- WAIT: rd_req = 0, timeout counter running, waiting for rd_valid.
- HOLD: word displayed; dwell counter running in auto mode.

Triggers (from IDLE or HOLD):
- Manual mode: sel_addr or src_sel differs from the registered show_addr/source, or a step rising edge. Target address is sel_addr.
- Auto mode: the dwell counter reaches DWELL-1, or a step rising edge. Target address is scan_addr+1, wrapping LAST_ADDR -> 0.
- First trigger after reset in auto mode: reads address 0 immediately, without waiting DWELL.

Transitions:
- Trigger: latch target into rd_addr/rd_src, set rd_req in the next cycle, go to REQ.
- REQ -> WAIT on the cycle rd_req & rd_gnt; rd_req drops the following cycle.
- WAIT -> HOLD on rd_valid:
  - show_data <= rd_data, show_addr <= rd_addr, show_valid <= 1, rd_err <= 0.
  - Dwell counter cleared.
- WAIT -> HOLD when the timeout counter reaches TIMEOUT without rd_valid:
  - show_data <= 32'hDEAD_DEAD, show_addr <= rd_addr, show_valid <= 1, rd_err <= 1.
  - The scan still advances normally.
- rd_valid outside WAIT is ignored. rd_valid in the same cycle the timeout fires counts as success.

Latency:
- Minimum trigger to show_valid update is 3 cycles: trigger, REQ with immediate grant, WAIT with rd_valid in the next cycle.
- busy = 1 exactly in REQ and WAIT.

Mid-transaction events:
- Changes to mode_auto, sel_addr or src_sel while busy do not disturb the transaction in flight.
- They are re-evaluated on entry to HOLD. In manual mode a mismatch retriggers at once.

Step and dwell:
- The step edge is detected against the registered previous level.
- Step edges while busy are dropped (not queued).
- The dwell counter counts only in HOLD with mode_auto = 1. It is cleared on a mode change and on any trigger.

Test Plan:
1. Reset release, mode_auto=0, sel_addr=5, src_sel=1, grant and valid one cycle each, rd_data=32'h1234_5678 -> rd_req=1 with rd_addr=5, rd_src=1; show_addr=5, show_data=32'h1234_5678, show_valid=1 three cycles after trigger.
2. Auto mode, DWELL=4, LAST_ADDR=3, immediate grant/valid -> reads of addresses 0,1,2,3,0 in order; each held 4 cycles in HOLD; wrap 3 -> 0 verified.
3. rd_gnt held low 10 cycles while in REQ -> rd_req stays 1; rd_addr/rd_src stable every cycle; no show update until grant.
4. Grant with no rd_valid, TIMEOUT=15 -> after 15 WAIT cycles show_data=32'hDEAD_DEAD, rd_err=1; next successful read clears rd_err to 0.
5. sel_addr changed and step pulsed while in WAIT -> in-flight read completes with the old address; exactly one new read of the new sel_addr follows; the step pulse is not replayed.
6. rst_n pulled low in WAIT, then rd_valid pulsed after release -> all outputs 0, state IDLE, show_valid stays 0 until a fresh trigger.

Source files
------------

// File: rtl/dbg_scan_ctrl.sv
// Debug inspection sequencer: issues handshaken, timeout-protected reads on the shared
// register-file/data-memory debug port and latches each word for the display mux.
module dbg_scan_ctrl #(
    parameter int ADDR_W    = 7,
    parameter int LAST_ADDR = 127,
    parameter int DWELL     = 25000000,
    parameter int TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_auto,
    input  logic [ADDR_W-1:0] sel_addr,
    input  logic              src_sel,
    input  logic              step,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_src,
    input  logic              rd_gnt,
    input  logic              rd_valid,
    input  logic [31:0]       rd_data,
    output logic [ADDR_W-1:0] show_addr,
    output logic [31:0]       show_data,
    output logic              show_valid,
    output logic              rd_err,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam int DW_W = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam int TO_W = $clog2(TIMEOUT + 1);

    localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] SCAN_LAST  = ADDR_W'(LAST_ADDR);
    localparam logic [31:0]       ERR_WORD   = 32'hDEAD_DEAD;

    logic [1:0]        state_q, state_d;
    logic              rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_src_q, rd_src_d;
    logic [ADDR_W-1:0] show_addr_q, show_addr_d;
    logic [31:0]       show_data_q, show_data_d;
    logic              show_valid_q, show_valid_d;
    logic              show_src_q, show_src_d;
    logic              rd_err_q, rd_err_d;
    logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
    logic              scan_started_q, scan_started_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              step_q;
    logic              mode_q;

    logic              step_rise;
    logic              trigger;
    logic [ADDR_W-1:0] next_scan;
    logic [ADDR_W-1:0] target;

    assign step_rise = step & ~step_q;

    // The very first auto trigger after reset reads address 0 rather than scan_addr+1.
    assign next_scan = !scan_started_q           ? '0 :
                       (scan_addr_q == SCAN_LAST) ? '0 :
                                                    scan_addr_q + ADDR_W'(1);

    assign target = mode_auto ? next_scan : sel_addr;

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no path leaves it unassigned (no latches).
        trigger = 1'b0;
        if (state_q == S_IDLE || state_q == S_HOLD) begin
            if (mode_auto)
                trigger = !scan_started_q || (dwell_q == DWELL_LAST) || step_rise;
            else
                trigger = (sel_addr != show_addr_q) || (src_sel != show_src_q) || step_rise;
        end
    end

    always_comb begin
        state_d        = state_q;
        rd_req_d       = rd_req_q;
        rd_addr_d      = rd_addr_q;
        rd_src_d       = rd_src_q;
        show_addr_d    = show_addr_q;
        show_data_d    = show_data_q;
        show_valid_d   = show_valid_q;
        show_src_d     = show_src_q;
        rd_err_d       = rd_err_q;
        scan_addr_d    = scan_addr_q;
        scan_started_d = scan_started_q;
        dwell_d        = (mode_auto != mode_q) ? '0 : dwell_q;
        to_cnt_d       = to_cnt_q;

        case (state_q)
            S_IDLE, S_HOLD: begin
                if (trigger) begin
                    state_d   = S_REQ;
                    rd_req_d  = 1'b1;
                    rd_addr_d = target;
                    rd_src_d  = src_sel;
                    dwell_d   = '0;
                    if (mode_auto) begin
                        scan_addr_d    = target;
                        scan_started_d = 1'b1;
                    end
                end else if (state_q == S_HOLD && mode_auto && mode_q) begin
                    dwell_d = dwell_q + DW_W'(1);
                end
            end
            S_REQ: begin
                if (rd_gnt) begin
                    state_d  = S_WAIT;
                    rd_req_d = 1'b0;
                    to_cnt_d = '0;
                end
            end
            S_WAIT: begin
                // A valid arriving on the timeout cycle still wins.
                if (rd_valid || to_cnt_q == TO_LAST) begin
                    state_d      = S_HOLD;
                    show_addr_d  = rd_addr_q;
                    show_src_d   = rd_src_q;
                    show_valid_d = 1'b1;
                    show_data_d  = rd_valid ? rd_data : ERR_WORD;
                    rd_err_d     = !rd_valid;
                    dwell_d      = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            rd_req_q       <= 1'b0;
            rd_addr_q      <= '0;
            rd_src_q       <= 1'b0;
            show_addr_q    <= '0;
            show_data_q    <= '0;
            show_valid_q   <= 1'b0;
            show_src_q     <= 1'b0;
            rd_err_q       <= 1'b0;
            scan_addr_q    <= '0;
            scan_started_q <= 1'b0;
            dwell_q        <= '0;
            to_cnt_q       <= '0;
            step_q         <= 1'b0;
            mode_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_req_q       <= rd_req_d;
            rd_addr_q      <= rd_addr_d;
            rd_src_q       <= rd_src_d;
            show_addr_q    <= show_addr_d;
            show_data_q    <= show_data_d;
            show_valid_q   <= show_valid_d;
            show_src_q     <= show_src_d;
            rd_err_q       <= rd_err_d;
            scan_addr_q    <= scan_addr_d;
            scan_started_q <= scan_started_d;
            dwell_q        <= dwell_d;
            to_cnt_q       <= to_cnt_d;
            step_q         <= step;
            mode_q         <= mode_auto;
        end
    end

    assign rd_req     = rd_req_q;
    assign rd_addr    = rd_addr_q;
    assign rd_src     = rd_src_q;
    assign show_addr  = show_addr_q;
    assign show_data  = show_data_q;
    assign show_valid = show_valid_q;
    assign rd_err     = rd_err_q;
    assign busy       = (state_q == S_REQ) || (state_q == S_WAIT);

endmodule

// File: tb/tb_dbg_scan_ctrl.sv
// Directed bench for dbg_scan_ctrl with a short dwell and small scan range.
module tb_dbg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode_auto;
    logic [6:0]  sel_addr;
    logic        src_sel;
    logic        step;
    logic        rd_req;
    logic [6:0]  rd_addr;
    logic        rd_src;
    logic        rd_gnt;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [6:0]  show_addr;
    logic [31:0] show_data;
    logic        show_valid;
    logic        rd_err;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    dbg_scan_ctrl #(
        .ADDR_W(7), .LAST_ADDR(3), .DWELL(4), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode_auto(mode_auto), .sel_addr(sel_addr),
        .src_sel(src_sel), .step(step), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_src(rd_src), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .show_addr(show_addr), .show_data(show_data), .show_valid(show_valid),
        .rd_err(rd_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req"},   {31'd0, rd_req},     32'd0);
        chk({tag, "_addr"},  {25'd0, rd_addr},    32'd0);
        chk({tag, "_src"},   {31'd0, rd_src},     32'd0);
        chk({tag, "_saddr"}, {25'd0, show_addr},  32'd0);
        chk({tag, "_sdata"}, show_data,           32'd0);
        chk({tag, "_svld"},  {31'd0, show_valid}, 32'd0);
        chk({tag, "_err"},   {31'd0, rd_err},     32'd0);
        chk({tag, "_busy"},  {31'd0, busy},       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; mode_auto = 1'b0; sel_addr = 7'd5; src_sel = 1'b1; step = 1'b0;
        rd_gnt = 1'b0; rd_valid = 1'b0; rd_data = '0;
        tick(); tick();
        chk_idle_outputs("reset");

        // 1: manual read of address 5 from data memory, minimum latency
        rst_n = 1'b1;
        tick();
        chk("t1_req",  {31'd0, rd_req}, 32'd1);
        chk("t1_addr", {25'd0, rd_addr}, 32'd5);
        chk("t1_src",  {31'd0, rd_src}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        rd_gnt = 1'b1;
        tick();
        chk("t1_req_drop", {31'd0, rd_req}, 32'd0);
        chk("t1_busy_wait", {31'd0, busy}, 32'd1);
        rd_gnt = 1'b0; rd_valid = 1'b1; rd_data = 32'h1234_5678;
        tick();
        rd_valid = 1'b0;
        chk("t1_saddr", {25'd0, show_addr}, 32'd5);
        chk("t1_sdata", show_data, 32'h1234_5678);
        chk("t1_svld",  {31'd0, show_valid}, 32'd1);
        chk("t1_err",   {31'd0, rd_err}, 32'd0);
        chk("t1_busy_hold", {31'd0, busy}, 32'd0);
        tick(); tick();
        chk("t1_no_retrigger", {31'd0, busy}, 32'd0);

        // 3: grant withheld for 10 cycles
        sel_addr = 7'd9; src_sel = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("t3_req_held", {31'd0, rd_req}, 32'd1);
            chk("t3_addr_stable", {25'd0, rd_addr}, 32'd9);
            chk("t3_src_stable", {31'd0, rd_src}, 32'd0);
            chk("t3_no_show", show_data, 32'h1234_5678);
            tick();
        end
        rd_gnt = 1'b1;
        tick();
        rd_gnt = 1'b0; rd_valid = 1'b1; rd_data = 32'hA5A5_0009;
        tick();
        rd_valid = 1'b0;
        chk("t3_saddr", {25'd0, show_addr}, 32'd9);
        chk("t3_sdata", show_data, 32'hA5A5_0009);

        // 4: timeout after 15 WAIT cycles, then a good read clears rd_err
        sel_addr = 7'd17;
        tick();
        rd_gnt = 1'b1;
        tick();
        rd_gnt = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("t4_still_wait", {31'd0, busy}, 32'd1);
        end
        tick();
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_sdata", show_data, 32'hDEAD_DEAD);
        chk("t4_saddr", {25'd0, show_addr}, 32'd17);
        chk("t4_err", {31'd0, rd_err}, 32'd1);
        chk("t4_svld", {31'd0, show_valid}, 32'd1);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("t4_step_req", {31'd0, rd_req}, 32'd1);
        rd_gnt = 1'b1;
        tick();
        rd_gnt = 1'b0; rd_valid = 1'b1; rd_data = 32'h0BAD_F00D;
        tick();
        rd_valid = 1'b0;
        chk("t4_err_clear", {31'd0, rd_err}, 32'd0);
        chk("t4_sdata2", show_data, 32'h0BAD_F00D);

        // 5: sel_addr change and step pulse during WAIT
        sel_addr = 7'd20;
        tick();
        rd_gnt = 1'b1;
        tick();
        rd_gnt = 1'b0; sel_addr = 7'd33; step = 1'b1;
        tick();
        step = 1'b0; rd_valid = 1'b1; rd_data = 32'h0000_0020;
        tick();
        rd_valid = 1'b0;
        chk("t5_old_addr", {25'd0, show_addr}, 32'd20);
        chk("t5_old_data", show_data, 32'h0000_0020);
        tick();
        chk("t5_new_req", {31'd0, rd_req}, 32'd1);
        chk("t5_new_addr", {25'd0, rd_addr}, 32'd33);
        rd_gnt = 1'b1;
        tick();
        rd_gnt = 1'b0; rd_valid = 1'b1; rd_data = 32'h0000_0033;
        tick();
        rd_valid = 1'b0;
        chk("t5_new_show", {25'd0, show_addr}, 32'd33);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_replay", {31'd0, busy}, 32'd0);
        end

        // 6: reset in WAIT, late rd_valid ignored
        sel_addr = 7'd40;
        tick();
        rd_gnt = 1'b1;
        tick();
        rd_gnt = 1'b0;
        chk("t6_in_wait", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("t6_async");
        sel_addr = 7'd0; src_sel = 1'b0;
        tick();
        rst_n = 1'b1;
        rd_valid = 1'b1; rd_data = 32'hFFFF_FFFF;
        tick();
        rd_valid = 1'b0;
        chk_idle_outputs("t6_late_valid");
        tick();
        chk("t6_still_idle", {31'd0, show_valid}, 32'd0);

        // 2: auto scan 0,1,2,3,0 with immediate grant/valid and 4-cycle dwell
        mode_auto = 1'b1; rd_gnt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t2_req", {31'd0, rd_req}, 32'd1);
            chk("t2_addr", {25'd0, rd_addr}, (k == 4) ? 32'd0 : k);
            tick();
            rd_valid = 1'b1; rd_data = 32'hC0DE_0000 + k;
            tick();
            rd_valid = 1'b0;
            chk("t2_saddr", {25'd0, show_addr}, (k == 4) ? 32'd0 : k);
            chk("t2_sdata", show_data, 32'hC0DE_0000 + k);
            for (int j = 0; j < 3; j++) begin
                tick();
                chk("t2_dwell", {31'd0, busy}, 32'd0);
            end
        end
        rd_gnt = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
